// File: rtl/alu_rr_arbiter_if.sv
// ============================================================================
// Module   : alu_rr_arbiter_if
// Purpose  : Requester and response channel bundle for alu_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_rr_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_a;
  logic [NREQ*4-1:0] req_b;
  logic [NREQ*2-1:0] req_f;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_y;
  logic              rsp_zero;
  logic              rsp_carry;
  logic              rsp_ovf;
  logic              rsp_neg;

  modport master (
    output req_valid, req_a, req_b, req_f, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_ovf, rsp_neg
  );

  modport slave (
    input  req_valid, req_a, req_b, req_f, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry, rsp_ovf, rsp_neg
  );
endinterface

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// Module   : alu_rr_arbiter
// Purpose  : Round-robin arbiter sharing one 4-bit ALU among NREQ requesters.
//            Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_rr_arbiter_if.slave       bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] c_op_add = 2'b00;
  localparam logic [1:0] c_op_sub = 2'b01;
  localparam logic [1:0] c_op_and = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           rsp_valid_d, rsp_valid_q;
  logic [3:0]     a_q, b_q;
  logic [1:0]     f_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] rsp_id_q;
  logic [3:0]     rsp_y_q;
  logic           rsp_zero_q, rsp_carry_q, rsp_ovf_q, rsp_neg_q;

  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           can_grant;
  logic           accept;

  // ---------------------------------------------------------------- grant
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        grant_idx = IDW'(i);
        grant_any = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] last_q;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && bus.req_valid[(int'(last_q) + k) % NREQ]) begin
        grant_idx = IDW'((int'(last_q) + k) % NREQ);
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDW'(NREQ - 1);
    end else if (accept) begin
      last_q <= grant_idx;
    end
  end
`endif

  assign can_grant     = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept        = rst_n && grant_any && can_grant;
  assign bus.req_ready = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

  // ---------------------------------------------------------------- ALU
  logic [3:0] alu_b;
  logic [4:0] alu_sum;
  logic [3:0] alu_y;
  logic       alu_carry, alu_ovf;

  // Subtract as A + ~B + 1 so carry-out reads as "no borrow".
  assign alu_b   = (f_q == c_op_sub) ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {4'b0000, (f_q == c_op_sub)};

  always_comb begin
    alu_y     = alu_sum[3:0];
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (f_q)
      c_op_add, c_op_sub: begin
        alu_carry = alu_sum[4];
        alu_ovf   = (a_q[3] == alu_b[3]) && (alu_sum[3] != a_q[3]);
      end
      c_op_and: alu_y = a_q & b_q;
      default:  alu_y = a_q | b_q;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? EXEC : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= '0;
      id_q <= '0;
    end else if (accept) begin
      a_q  <= bus.req_a[4*int'(grant_idx) +: 4];
      b_q  <= bus.req_b[4*int'(grant_idx) +: 4];
      f_q  <= bus.req_f[2*int'(grant_idx) +: 2];
      id_q <= grant_idx;
    end
  end

  // Response fields load only in EXEC, so they stay frozen while RESP stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_id_q    <= id_q;
      rsp_y_q     <= alu_y;
      rsp_zero_q  <= (alu_y == 4'd0);
      rsp_carry_q <= alu_carry;
      rsp_ovf_q   <= alu_ovf;
      rsp_neg_q   <= alu_y[3];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_neg   = rsp_neg_q;

endmodule

`default_nettype wire
